// File: rtl/inst_wb_buf.sv
// Write-back stage: retiring instructions queue register writes in a small FIFO
// that drains to the register file in order, with forwarding lookup and optional bypass.
module inst_wb_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_ctrl,
  input  logic              valid_ctrl,
  input  logic [ADDR_W-1:0] rc_addr,
  input  logic [DATA_W-1:0] rc_data,
  input  logic              rf_w_en,
  input  logic [3:0]        opcode,
  output logic              in_ready,
  input  logic              rf_w_ready,
  output logic              rf_w_en_out,
  output logic [ADDR_W-1:0] rc_addr_out,
  output logic [DATA_W-1:0] rc_data_out,
  output logic              regsel_out,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              complete,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic              drop_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              complete_q, complete_d;
  logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
  logic              drop_err_q, drop_err_d;

  logic full, empty, accept, bypass, push, pop;

  // Opcode travels with the instruction for debug visibility only.
  logic unused_opcode;
  assign unused_opcode = ^opcode;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !rst && !full;
  assign accept   = en_ctrl && valid_ctrl && in_ready;
  assign bypass   = (BYPASS != 0) && empty && accept && rf_w_en && rf_w_ready;
  assign push     = accept && rf_w_en && !bypass;
  assign pop      = !rst && !empty && rf_w_ready;

  always_comb begin
    rf_w_en_out = 1'b0;
    rc_addr_out = '0;
    rc_data_out = '0;
    if (!rst) begin
      if (!empty) begin
        rf_w_en_out = 1'b1;
        rc_addr_out = mem_addr_q[rd_ptr_q];
        rc_data_out = mem_data_q[rd_ptr_q];
      end else if (bypass) begin
        rf_w_en_out = 1'b1;
        rc_addr_out = rc_addr;
        rc_data_out = rc_data;
      end
    end
  end

  assign regsel_out = rf_w_en_out;

  // Walk from oldest to youngest so the last match found is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr_q + PTR_W'(k);
        if (((PTR_W+1)'(k) < count_q) && (mem_addr_q[idx] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = mem_data_q[idx];
        end
      end
    end
  end

  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    complete_d    = accept;
    retired_cnt_d = retired_cnt_q;
    drop_err_d    = drop_err_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = rc_addr;
      mem_data_d[wr_ptr_q] = rc_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
    if (accept) begin
      retired_cnt_d = retired_cnt_q + CNT_W'(1);
    end
    if (en_ctrl && valid_ctrl && !in_ready) begin
      drop_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      complete_q    <= 1'b0;
      retired_cnt_q <= '0;
      drop_err_q    <= 1'b0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      complete_q    <= complete_d;
      retired_cnt_q <= retired_cnt_d;
      drop_err_q    <= drop_err_d;
    end
  end

  assign complete    = complete_q;
  assign retired_cnt = retired_cnt_q;
  assign drop_err    = drop_err_q;

endmodule
